// File: rtl/brick_field_pkg.sv
// Shared constants for the Breakout brick field: screen size, default brick geometry,
// hit FSM state encodings and an index-width helper.
package brick_field_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DEF_ROWS     = 6;
    localparam int DEF_COLS     = 6;
    localparam int DEF_BRK_W    = 74;
    localparam int DEF_BRK_H    = 8;
    localparam int DEF_X_ORIGIN = 160;
    localparam int DEF_Y_ORIGIN = 8;

    typedef logic [1:0] hit_state_t;

    localparam hit_state_t ST_IDLE   = 2'd0;
    localparam hit_state_t ST_LOCATE = 2'd1;
    localparam hit_state_t ST_CLEAR  = 2'd2;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brick_locate.sv
// Combinational point-to-brick lookup: parallel compares of (x,y) against constant
// brick boundaries, no division.
module brick_locate
    import brick_field_pkg::*;
#(
    parameter int NUM_ROWS = DEF_ROWS,
    parameter int NUM_COLS = DEF_COLS,
    parameter int BRK_W    = DEF_BRK_W,
    parameter int BRK_H    = DEF_BRK_H,
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    localparam int ROW_W   = idx_width(NUM_ROWS),
    localparam int COL_W   = idx_width(NUM_COLS)
) (
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    output logic             in_field,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    logic [10:0] x11;
    logic [10:0] y11;
    logic        col_hit;
    logic        row_hit;

    assign x11 = {1'b0, x};
    assign y11 = {2'b00, y};

    // Half-open intervals guarantee at most one column and one row match.
    always_comb begin
        col_hit = 1'b0;
        col     = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (x11 >= 11'(X_ORIGIN + BRK_W * c) && x11 < 11'(X_ORIGIN + BRK_W * (c + 1))) begin
                col_hit = 1'b1;
                col     = COL_W'(c);
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row     = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (y11 >= 11'(Y_ORIGIN + BRK_H * r) && y11 < 11'(Y_ORIGIN + BRK_H * (r + 1))) begin
                row_hit = 1'b1;
                row     = ROW_W'(r);
            end
        end
    end

    assign in_field = col_hit & row_hit;

endmodule

// File: rtl/brick_field.sv
// Breakout brick wall: alive bitmap, registered pixel lookup for drawing, and a
// three-state collision query engine that clears struck bricks.
//
// state  | meaning
// IDLE   | ready for a query; hit_ready high
// LOCATE | query point latched; registering field/row/col lookup
// CLEAR  | test alive bit, clear on hit, issue hit_ack next cycle
module brick_field
    import brick_field_pkg::*;
#(
    parameter int NUM_ROWS = DEF_ROWS,
    parameter int NUM_COLS = DEF_COLS,
    parameter int BRK_W    = DEF_BRK_W,
    parameter int BRK_H    = DEF_BRK_H,
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    localparam int ROW_W   = idx_width(NUM_ROWS),
    localparam int COL_W   = idx_width(NUM_COLS),
    localparam int NB      = NUM_ROWS * NUM_COLS,
    localparam int CNT_W   = $clog2(NB + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       cnt_x,
    input  logic [8:0]       cnt_y,
    input  logic             level_load,
    input  logic             hit_req,
    input  logic [9:0]       hit_x,
    input  logic [8:0]       hit_y,
    output logic             hit_ready,
    output logic             hit_ack,
    output logic             hit_valid,
    output logic [ROW_W-1:0] hit_row,
    output logic [COL_W-1:0] hit_col,
    output logic             bricks,
    output logic [ROW_W-1:0] brick_row,
    output logic [CNT_W-1:0] bricks_left,
    output logic             level_clear
);

    localparam int IDX_W = idx_width(NB);

    if (X_ORIGIN + BRK_W * NUM_COLS > SCREEN_W || Y_ORIGIN + BRK_H * NUM_ROWS > SCREEN_H) begin : g_bad_geometry
        $error("brick_field: brick wall does not fit on the screen");
    end

    logic [NB-1:0]    alive;
    hit_state_t       state;

    logic             pix_in;
    logic [ROW_W-1:0] pix_row;
    logic [COL_W-1:0] pix_col;
    logic [IDX_W-1:0] pix_idx;

    logic [9:0]       hx;
    logic [8:0]       hy;
    logic             q_in;
    logic [ROW_W-1:0] q_row;
    logic [COL_W-1:0] q_col;
    logic             loc_in;
    logic [ROW_W-1:0] loc_row;
    logic [COL_W-1:0] loc_col;
    logic [IDX_W-1:0] loc_idx;

    brick_locate #(
        .NUM_ROWS (NUM_ROWS), .NUM_COLS (NUM_COLS), .BRK_W (BRK_W), .BRK_H (BRK_H),
        .X_ORIGIN (X_ORIGIN), .Y_ORIGIN (Y_ORIGIN)
    ) u_pix_locate (
        .x (cnt_x), .y (cnt_y), .in_field (pix_in), .row (pix_row), .col (pix_col)
    );

    brick_locate #(
        .NUM_ROWS (NUM_ROWS), .NUM_COLS (NUM_COLS), .BRK_W (BRK_W), .BRK_H (BRK_H),
        .X_ORIGIN (X_ORIGIN), .Y_ORIGIN (Y_ORIGIN)
    ) u_hit_locate (
        .x (hx), .y (hy), .in_field (q_in), .row (q_row), .col (q_col)
    );

    assign pix_idx   = IDX_W'(int'(pix_row) * NUM_COLS + int'(pix_col));
    assign loc_idx   = IDX_W'(int'(loc_row) * NUM_COLS + int'(loc_col));
    assign hit_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            bricks    <= 1'b0;
            brick_row <= '0;
        end else begin
            bricks    <= pix_in & alive[pix_idx];
            brick_row <= (pix_in && alive[pix_idx]) ? pix_row : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            alive       <= '1;
            bricks_left <= CNT_W'(NB);
            hit_ack     <= 1'b0;
            hit_valid   <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            level_clear <= 1'b0;
            hx          <= '0;
            hy          <= '0;
            loc_in      <= 1'b0;
            loc_row     <= '0;
            loc_col     <= '0;
        end else begin
            hit_ack     <= 1'b0;
            level_clear <= 1'b0;
            if (level_load) begin
                // Restoring the wall also abandons any query in flight.
                alive       <= '1;
                bricks_left <= CNT_W'(NB);
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (hit_req) begin
                            hx    <= hit_x;
                            hy    <= hit_y;
                            state <= ST_LOCATE;
                        end
                    end
                    ST_LOCATE: begin
                        loc_in  <= q_in;
                        loc_row <= q_row;
                        loc_col <= q_col;
                        state   <= ST_CLEAR;
                    end
                    ST_CLEAR: begin
                        hit_ack <= 1'b1;
                        state   <= ST_IDLE;
                        if (loc_in && alive[loc_idx] && bricks_left != '0) begin
                            alive[loc_idx] <= 1'b0;
                            bricks_left    <= bricks_left - 1'b1;
                            hit_valid      <= 1'b1;
                            hit_row        <= loc_row;
                            hit_col        <= loc_col;
                            level_clear    <= (bricks_left == CNT_W'(1));
                        end else begin
                            hit_valid <= 1'b0;
                            hit_row   <= '0;
                            hit_col   <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field with default geometry (6x6 bricks of 74x8 at 160,8).
`timescale 1ns/1ps
module tb_brick_field;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] cnt_x = '0;
    logic [8:0] cnt_y = '0;
    logic       level_load = 1'b0;
    logic       hit_req = 1'b0;
    logic [9:0] hit_x = '0;
    logic [8:0] hit_y = '0;
    logic       hit_ready;
    logic       hit_ack;
    logic       hit_valid;
    logic [2:0] hit_row;
    logic [2:0] hit_col;
    logic       bricks;
    logic [2:0] brick_row;
    logic [5:0] bricks_left;
    logic       level_clear;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int lc_cnt = 0;

    brick_field dut (
        .clk (clk), .reset (reset), .cnt_x (cnt_x), .cnt_y (cnt_y),
        .level_load (level_load), .hit_req (hit_req), .hit_x (hit_x), .hit_y (hit_y),
        .hit_ready (hit_ready), .hit_ack (hit_ack), .hit_valid (hit_valid),
        .hit_row (hit_row), .hit_col (hit_col), .bricks (bricks), .brick_row (brick_row),
        .bricks_left (bricks_left), .level_clear (level_clear)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hit_ack) ack_cnt++;
        if (level_clear) lc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y);
        cnt_x = 10'(x);
        cnt_y = 9'(y);
        tick();
    endtask

    // Issues one query and returns once hit_ack is seen (or the budget runs out).
    task automatic do_hit(input int x, input int y, output int lat, output logic v,
                          output logic [2:0] r, output logic [2:0] c, output logic lc);
        hit_x   = 10'(x);
        hit_y   = 9'(y);
        hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        lat = 1;
        while (!hit_ack && lat < 8) begin
            tick();
            lat++;
        end
        v  = hit_valid;
        r  = hit_row;
        c  = hit_col;
        lc = level_clear;
    endtask

    initial begin
        int lat;
        logic v, lc;
        logic [2:0] r, c;
        int nvalid, drawn, row_bad, acks0;

        tick();
        tick();
        chk("rst_bricks_left", bricks_left, 36);
        chk("rst_hit_ready", hit_ready, 1);
        chk("rst_hit_ack", hit_ack, 0);
        chk("rst_bricks", bricks, 0);
        chk("rst_level_clear", level_clear, 0);
        reset = 1'b0;

        pixel(160, 8);  chk("pix_160_8", bricks, 1);  chk("pix_160_8_row", brick_row, 0);
        pixel(233, 8);  chk("pix_233_8", bricks, 1);  chk("pix_233_8_row", brick_row, 0);
        pixel(234, 8);  chk("pix_234_8", bricks, 1);  chk("pix_234_8_row", brick_row, 0);
        pixel(159, 8);  chk("pix_159_8", bricks, 0);
        pixel(160, 56); chk("pix_160_56", bricks, 0);
        pixel(235, 17); chk("pix_235_17_pre", bricks, 1); chk("pix_235_17_row", brick_row, 1);
        chk("bricks_left_init", bricks_left, 36);

        do_hit(235, 17, lat, v, r, c, lc);
        chk("hit1_latency", lat, 3);
        chk("hit1_valid", v, 1);
        chk("hit1_row", r, 1);
        chk("hit1_col", c, 1);
        tick();
        chk("hit1_left", bricks_left, 35);
        pixel(235, 17); chk("pix_235_17_post", bricks, 0);

        do_hit(235, 17, lat, v, r, c, lc);
        chk("rehit_latency", lat, 3);
        chk("rehit_valid", v, 0);
        do_hit(100, 17, lat, v, r, c, lc);
        chk("outside_latency", lat, 3);
        chk("outside_valid", v, 0);
        chk("outside_row", r, 0);
        chk("outside_col", c, 0);
        tick();
        chk("miss_left", bricks_left, 35);

        nvalid = 0;
        for (int rr = 0; rr < 6; rr++) begin
            for (int cc = 0; cc < 6; cc++) begin
                do_hit(160 + 74 * cc + 10, 8 + 8 * rr + 3, lat, v, r, c, lc);
                if (v) nvalid++;
            end
        end
        chk("sweep_valid_hits", nvalid, 35);
        chk("sweep_last_lc", lc, 1);
        chk("sweep_last_row", r, 5);
        chk("sweep_last_col", c, 5);
        tick();
        chk("sweep_left", bricks_left, 0);
        chk("sweep_lc_pulses", lc_cnt, 1);

        level_load = 1'b1;
        tick();
        level_load = 1'b0;
        chk("load_left", bricks_left, 36);
        drawn = 0;
        row_bad = 0;
        for (int rr = 0; rr < 6; rr++) begin
            for (int cc = 0; cc < 6; cc++) begin
                pixel(160 + 74 * cc + 5, 8 + 8 * rr + 2);
                if (bricks) drawn++;
                if (brick_row != 3'(rr)) row_bad++;
            end
        end
        chk("load_drawn", drawn, 36);
        chk("load_row_errors", row_bad, 0);
        chk("load_lc_pulses", lc_cnt, 1);

        acks0 = ack_cnt;
        hit_x = 10'd235; hit_y = 9'd17; hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        chk("locate_busy", hit_ready, 0);
        level_load = 1'b1;
        tick();
        level_load = 1'b0;
        chk("abort_ready", hit_ready, 1);
        tick(); tick(); tick();
        chk("abort_no_ack", ack_cnt - acks0, 0);
        chk("abort_left", bricks_left, 36);

        acks0 = ack_cnt;
        hit_x = 10'd235; hit_y = 9'd17; hit_req = 1'b1;
        tick();
        tick();
        tick();
        chk("held_ack", hit_ack, 1);
        hit_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("held_once", ack_cnt - acks0, 1);
        chk("held_left", bricks_left, 35);

        pixel(320, 20); chk("pix_320_20", bricks, 1);
        acks0 = ack_cnt;
        hit_x = 10'd400; hit_y = 9'd30; hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rstq_ack", hit_ack, 0);
        chk("rstq_valid", hit_valid, 0);
        chk("rstq_row", hit_row, 0);
        chk("rstq_col", hit_col, 0);
        chk("rstq_bricks", bricks, 0);
        chk("rstq_left", bricks_left, 36);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rstq_no_ack", ack_cnt - acks0, 0);
        chk("rstq_ready", hit_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
